execute_sequencer: RTL and testbench

- Execute-stage controller for the sequential Y86-64 core. It is the initiator side of the 64-bit ALU interface.
- Accepts one decoded instruction per transaction and selects the ALU operands and function code. It samples the combinational ALU result.
- Owns the condition-code register (ZF/SF/OF), computes Cnd and returns valE.
- Sits between decode and memory stages; valid/ready handshakes on both sides.

---
 rtl/y86_pkg.sv | 61 ++++++
 rtl/cond_eval.sv | 41 ++++
 rtl/execute_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_execute_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 encodings for the execute stage:
//   - instruction codes (I_HALT .. I_POPQ)
//   - ALU function codes (ALU_ADD .. ALU_XOR)
//   - jXX / cmovXX condition codes (C_ALWAYS .. C_G)
//   - default stack pointer step and the execute sequencer state encoding
//   - decode_error(): flags icode/ifun combinations the core cannot execute
// ---------------------------------------------------------------------------
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_XOR = 3'd3;

  localparam logic [3:0] C_ALWAYS = 4'd0;
  localparam logic [3:0] C_LE     = 4'd1;
  localparam logic [3:0] C_L      = 4'd2;
  localparam logic [3:0] C_E      = 4'd3;
  localparam logic [3:0] C_NE     = 4'd4;
  localparam logic [3:0] C_GE     = 4'd5;
  localparam logic [3:0] C_G      = 4'd6;

  localparam int STACK_STEP_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } exec_state_t;

  // Unknown icodes, OPq with a non-ALU function, and cmovXX/jXX with an
  // undefined condition are all rejected the same way.
  function automatic logic decode_error(input logic [3:0] icode,
                                        input logic [3:0] ifun);
    logic bad;
    bad = 1'b0;
    if (icode > I_POPQ)
      bad = 1'b1;
    else if (icode == I_OPQ && ifun > 4'd3)
      bad = 1'b1;
    else if ((icode == I_RRMOVQ || icode == I_JXX) && ifun > C_G)
      bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Combinational Y86 condition evaluator, shared by cmovXX and jXX.
// Ports:
//   cc    in  3  {ZF,SF,OF}
//   ifun  in  4  condition selector (C_ALWAYS .. C_G)
//   cnd   out 1  condition outcome; 0 for undefined selectors
// ---------------------------------------------------------------------------
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic zf;
  logic sf;
  logic of;

  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  // Signed comparisons use SF^OF as "less than", which stays correct even
  // when the subtraction that set the flags overflowed.
  always_comb begin
    cnd = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = (sf ^ of) | zf;
      C_L:      cnd = sf ^ of;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~(sf ^ of);
      C_G:      cnd = ~(sf ^ of) & ~zf;
      default:  cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_sequencer.sv
// ---------------------------------------------------------------------------
// execute_sequencer
// Execute-stage controller for the sequential Y86-64 core. Latches one
// decoded instruction, drives the external combinational ALU, captures valE,
// evaluates cnd and owns the {ZF,SF,OF} condition-code register.
// Ports:
//   clk, reset                 clock, async active-high reset
//   in_valid/in_ready          decode-side handshake
//   icode, ifun, valA/B/C      decoded instruction fields
//   alu_x, alu_y, alu_ctrl     ALU operands and function (0 add,1 sub,2 and,3 xor)
//   alu_result                 combinational ALU result
//   out_valid/out_ready        memory-side handshake
//   valE, cnd, err             execute results, held while out_valid
//   cc                         current {ZF,SF,OF}
// Optional (macro EXEC_PERF_CNT_EN):
//   op_count        32  completed executions (EXEC->DONE)
//   cc_write_count  32  condition-code register updates
// ---------------------------------------------------------------------------
module execute_sequencer
  import y86_pkg::*;
#(
  parameter int W          = 64,
  parameter int STACK_STEP = STACK_STEP_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  output logic [W-1:0] alu_x,
  output logic [W-1:0] alu_y,
  output logic [2:0]   alu_ctrl,
  input  logic [W-1:0] alu_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] valE,
  output logic         cnd,
  output logic         err,
  output logic [2:0]   cc
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [31:0]  op_count,
  output logic [31:0]  cc_write_count
`endif
);

  localparam logic [W-1:0] STEP = W'(STACK_STEP);

  exec_state_t state;
  exec_state_t state_next;

  logic [3:0]   icode_q;
  logic [3:0]   ifun_q;
  logic [W-1:0] vala_q;
  logic [W-1:0] valb_q;
  logic [W-1:0] valc_q;

  logic accept;
  logic err_c;
  logic cond_out;
  logic cnd_c;
  logic of_c;
  logic cc_write;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // Next state and handshakes. DONE with out_ready opens the input side in
  // the same cycle so a waiting instruction goes straight back into EXEC.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_next = S_EXEC;
      end
      S_EXEC: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready   = 1'b1;
          state_next = in_valid ? S_EXEC : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // ALU operands come straight from the latched fields. Those reset to a
  // halt with zero operands, which makes the ALU interface read 0+0 after
  // reset without extra output registers.
  always_comb begin
    alu_x    = '0;
    alu_y    = '0;
    alu_ctrl = ALU_ADD;
    case (icode_q)
      I_RRMOVQ: alu_x = vala_q;
      I_IRMOVQ: alu_x = valc_q;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_x = valb_q;
        alu_y = valc_q;
      end
      I_OPQ: begin
        alu_x    = valb_q;
        alu_y    = vala_q;
        alu_ctrl = {1'b0, ifun_q[1:0]};
      end
      I_CALL, I_PUSHQ: begin
        alu_x    = valb_q;
        alu_y    = STEP;
        alu_ctrl = ALU_SUB;
      end
      I_RET, I_POPQ: begin
        alu_x = valb_q;
        alu_y = STEP;
      end
      default: ;
    endcase
  end

  // Signed overflow from operand and result sign bits; logic ops never
  // overflow.
  always_comb begin
    of_c = 1'b0;
    case (alu_ctrl)
      ALU_ADD: of_c = (alu_x[W-1] == alu_y[W-1]) && (alu_result[W-1] != alu_x[W-1]);
      ALU_SUB: of_c = (alu_x[W-1] != alu_y[W-1]) && (alu_result[W-1] != alu_x[W-1]);
      default: of_c = 1'b0;
    endcase
  end

  cond_eval u_cond_eval (
    .cc   (cc),
    .ifun (ifun_q),
    .cnd  (cond_out)
  );

  assign err_c    = decode_error(icode_q, ifun_q);
  assign cnd_c    = (icode_q == I_RRMOVQ || icode_q == I_JXX) ? cond_out : 1'b1;
  assign cc_write = (state == S_EXEC) && (icode_q == I_OPQ) && !err_c;

  // Instruction latch and result capture. cnd is taken from the flags as
  // they stand before this instruction's own update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      icode_q <= I_HALT;
      ifun_q  <= 4'd0;
      vala_q  <= '0;
      valb_q  <= '0;
      valc_q  <= '0;
      valE    <= '0;
      cnd     <= 1'b0;
      err     <= 1'b0;
      cc      <= 3'b100;
    end else begin
      if (accept) begin
        icode_q <= icode;
        ifun_q  <= ifun;
        vala_q  <= valA;
        valb_q  <= valB;
        valc_q  <= valC;
      end
      if (state == S_EXEC) begin
        valE <= err_c ? '0 : alu_result;
        cnd  <= err_c ? 1'b0 : cnd_c;
        err  <= err_c;
      end
      if (cc_write)
        cc <= {(alu_result == '0), alu_result[W-1], of_c};
    end
  end

`ifdef EXEC_PERF_CNT_EN
  // Free-running activity counters, wrapping naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count       <= 32'd0;
      cc_write_count <= 32'd0;
    end else begin
      if (state == S_EXEC)
        op_count <= op_count + 32'd1;
      if (cc_write)
        cc_write_count <= cc_write_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_execute_sequencer.sv
// ---------------------------------------------------------------------------
// tb_execute_sequencer
// Directed bench for execute_sequencer with a behavioural 64-bit ALU.
// Expected results are queued when an instruction is accepted and checked
// by a separate monitor at each output handshake.
// ---------------------------------------------------------------------------
module tb_execute_sequencer;

  typedef struct {
    logic [63:0] val;
    logic        cnd;
    logic        err;
    logic [2:0]  cc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic [63:0] alu_x;
  logic [63:0] alu_y;
  logic [2:0]  alu_ctrl;
  logic [63:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] valE;
  logic        cnd;
  logic        err;
  logic [2:0]  cc;

  exp_t  sbq[$];
  string tagq[$];
  int    compared = 0;
  int    failed   = 0;
  int    cycleCount = 0;
  int    lastAccept = 0;
  int    prevAccept = 0;

  execute_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .icode      (icode),
    .ifun       (ifun),
    .valA       (valA),
    .valB       (valB),
    .valC       (valC),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .valE       (valE),
    .cnd        (cnd),
    .err        (err),
    .cc         (cc)
  );

  // Behavioural ALU on the initiator's operands.
  always_comb begin
    case (alu_ctrl)
      3'd0:    alu_result = alu_x + alu_y;
      3'd1:    alu_result = alu_x - alu_y;
      3'd2:    alu_result = alu_x & alu_y;
      3'd3:    alu_result = alu_x ^ alu_y;
      default: alu_result = 64'd0;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount <= cycleCount + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one instruction, wait (bounded) for in_ready, then queue its
  // expected result. Returns one step after the accepting edge (EXEC).
  task automatic applyStimulus(input string tag, input logic [3:0] ic,
                               input logic [3:0] fn, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] c,
                               input logic [63:0] eVal, input logic eCnd,
                               input logic eErr, input logic [2:0] eCc);
    exp_t e;
    int   waitCycles;
    icode    = ic;
    ifun     = fn;
    valA     = a;
    valB     = b;
    valC     = c;
    in_valid = 1'b1;
    waitCycles = 0;
    while (!in_ready && waitCycles < 50) begin
      @(posedge clk);
      #1;
      waitCycles++;
    end
    if (!in_ready) begin
      compared++;
      failed++;
      $display("[TB] FAIL accept_timeout %s: in_ready stayed 0, expected 1", tag);
      in_valid = 1'b0;
      return;
    end
    e.val = eVal;
    e.cnd = eCnd;
    e.err = eErr;
    e.cc  = eCc;
    sbq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    prevAccept = lastAccept;
    lastAccept = cycleCount;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Monitor: pops and compares on every output handshake.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          compared++;
          failed++;
          $display("[TB] FAIL unexpected_output: valE %h with empty queue, expected no output", valE);
        end else begin
          e = sbq.pop_front();
          t = tagq.pop_front();
          checkOutput({t, ".valE"}, valE, e.val);
          checkOutput({t, ".cnd"}, {63'd0, cnd}, {63'd0, e.cnd});
          checkOutput({t, ".err"}, {63'd0, err}, {63'd0, e.err});
          checkOutput({t, ".cc"}, {61'd0, cc}, {61'd0, e.cc});
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    icode     = 4'h0;
    ifun      = 4'h0;
    valA      = 64'd0;
    valB      = 64'd0;
    valC      = 64'd0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst.valE", valE, 64'd0);
    checkOutput("rst.cnd", {63'd0, cnd}, 64'd0);
    checkOutput("rst.err", {63'd0, err}, 64'd0);
    checkOutput("rst.cc", {61'd0, cc}, 64'd4);
    checkOutput("rst.alu_x", alu_x, 64'd0);
    checkOutput("rst.alu_y", alu_y, 64'd0);
    checkOutput("rst.alu_ctrl", {61'd0, alu_ctrl}, 64'd0);
    checkOutput("rst.in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b0;

    // Reset while an overflowing add sits in EXEC: nothing may escape.
    @(posedge clk);
    #1;
    icode    = 4'h6;
    ifun     = 4'h0;
    valA     = 64'd1;
    valB     = 64'h7FFF_FFFF_FFFF_FFFF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("midrst.in_ready_exec", {63'd0, in_ready}, 64'd0);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst.out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst.cc", {61'd0, cc}, 64'd4);
    checkOutput("midrst.in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst.next_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midrst.next_cc", {61'd0, cc}, 64'd4);
    checkOutput("midrst.next_in_ready", {63'd0, in_ready}, 64'd1);

    // Overflowing add, with operand and latency checks.
    applyStimulus("add_ovf", 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0,
                  64'h8000_0000_0000_0000, 1'b1, 1'b0, 3'b011);
    checkOutput("add_ovf.alu_x", alu_x, 64'h7FFF_FFFF_FFFF_FFFF);
    checkOutput("add_ovf.alu_y", alu_y, 64'd1);
    checkOutput("add_ovf.lat1_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("add_ovf.lat2_out_valid", {63'd0, out_valid}, 64'd1);

    applyStimulus("sub_eq", 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 64'd0, 1'b1, 1'b0, 3'b100);
    applyStimulus("cmovle", 4'h2, 4'h1, 64'h1234, 64'd0, 64'd0, 64'h1234, 1'b1, 1'b0, 3'b100);
    applyStimulus("pushq", 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 64'hF8, 1'b1, 1'b0, 3'b100);
    checkOutput("pushq.alu_ctrl", {61'd0, alu_ctrl}, 64'd1);
    applyStimulus("popq", 4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 64'h100, 1'b1, 1'b0, 3'b100);
    checkOutput("b2b.accept_gap", 64'(lastAccept - prevAccept), 64'd2);
    applyStimulus("bad_icode", 4'hC, 4'h0, 64'd1, 64'd2, 64'd3, 64'd0, 1'b0, 1'b1, 3'b100);
    applyStimulus("bad_opq", 4'h6, 4'h4, 64'd1, 64'd2, 64'd0, 64'd0, 1'b0, 1'b1, 3'b100);
    applyStimulus("sub_neg", 4'h6, 4'h1, 64'd5, 64'd3, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 3'b010);
    applyStimulus("jl_t", 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b010);
    applyStimulus("jg_f", 4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b010);
    applyStimulus("jne_t", 4'h7, 4'h4, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b010);
    applyStimulus("je_f", 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b010);
    applyStimulus("and_zero", 4'h6, 4'h2, 64'h0F, 64'hF0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b100);
    applyStimulus("je_t", 4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b100);
    applyStimulus("xor_neg", 4'h6, 4'h3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'b010);
    applyStimulus("sub_ovf", 4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 3'b001);
    applyStimulus("jl_ovf", 4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0, 3'b001);
    applyStimulus("jge_f", 4'h7, 4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 3'b001);
    applyStimulus("bad_cmov", 4'h2, 4'h7, 64'h55, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 3'b001);
    applyStimulus("call_wrap", 4'h8, 4'h0, 64'd0, 64'd0, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 1'b0, 3'b001);
    applyStimulus("ret_wrap", 4'h9, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0,
                  64'd4, 1'b1, 1'b0, 3'b001);
    applyStimulus("rrmovq", 4'h2, 4'h0, 64'h77, 64'd0, 64'd0, 64'h77, 1'b1, 1'b0, 3'b001);
    applyStimulus("mrmovq", 4'h5, 4'h0, 64'd0, 64'h1000, 64'h20, 64'h1020, 1'b1, 1'b0, 3'b001);
    applyStimulus("halt", 4'h0, 4'h0, 64'h9, 64'h9, 64'h9, 64'd0, 1'b1, 1'b0, 3'b001);
    drain();

    // Back-pressure: results must hold while out_ready is low.
    out_ready = 1'b0;
    applyStimulus("irmovq_hold", 4'h3, 4'h0, 64'd0, 64'd0, 64'hBEEF,
                  64'hBEEF, 1'b1, 1'b0, 3'b001);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold.out_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("hold.valE", valE, 64'hBEEF);
      checkOutput("hold.cnd", {63'd0, cnd}, 64'd1);
      checkOutput("hold.in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    checkOutput("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
